// File: rtl/apb2axi_pkg.sv
// ============================================================================
// Module  : apb2axi_pkg
// Purpose : Shared tag-state encoding and sizing constants for the scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package apb2axi_pkg;

  localparam int TAG_NUM         = 8;
  localparam int TAG_W           = $clog2(TAG_NUM);
  localparam int TAG_STATE_W     = 2;
  localparam int TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [TAG_STATE_W-1:0] {
    TAG_FREE   = 2'd0,
    TAG_PEND   = 2'd1,
    TAG_ISSUED = 2'd2,
    TAG_DONE   = 2'd3
  } tag_state_e;

endpackage

`default_nettype wire

// File: rtl/apb2axi_rr_arbiter.sv
// ============================================================================
// Module  : apb2axi_rr_arbiter
// Purpose : Round-robin pick over a request vector, starting after ptr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb2axi_rr_arbiter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant_idx,
  output logic         grant_any
);

  int idx;

  // The pointer slot itself is visited last, giving it lowest priority.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!grant_any && req[idx]) begin
        grant_any = 1'b1;
        grant_idx = W'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb2axi_tag_scheduler.sv
// ============================================================================
// Module  : apb2axi_tag_scheduler
// Purpose : Tag life cycle FREE->PEND->ISSUED->DONE->FREE with RR issue ports.
// Option  : APB2AXI_SCHED_TIMEOUT_EN adds a per-tag issue watchdog.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb2axi_tag_scheduler
  import apb2axi_pkg::*;
#(
  parameter int TAG_NUM_P     = TAG_NUM,
  parameter int TAG_W_P       = TAG_W,
  parameter int TIMEOUT_CYC_P = TIMEOUT_CYC_DEF
) (
  input  logic                            pclk,
  input  logic                            preset,
  input  logic                            commit_pulse,
  input  logic                            commit_is_write,
  output logic [TAG_W_P-1:0]              alloc_tag,
  output logic                            full,
  output logic                            rd_issue_valid,
  output logic [TAG_W_P-1:0]              rd_issue_tag,
  input  logic                            rd_issue_ready,
  output logic                            wr_issue_valid,
  output logic [TAG_W_P-1:0]              wr_issue_tag,
  input  logic                            wr_issue_ready,
  input  logic                            cpl_valid,
  input  logic [TAG_W_P-1:0]              cpl_tag,
  input  logic                            cpl_err,
  input  logic                            rel_valid,
  input  logic [TAG_W_P-1:0]              rel_tag,
  output logic [TAG_STATE_W*TAG_NUM_P-1:0] tag_state,
  output logic [TAG_NUM_P-1:0]            tag_err,
  output logic                            overflow,
  output logic                            proto_err
`ifdef APB2AXI_SCHED_TIMEOUT_EN
  ,
  output logic                            timeout_pulse,
  output logic [TAG_W_P-1:0]              timeout_tag
`endif
);

  if (TAG_W_P != $clog2(TAG_NUM_P) || TIMEOUT_CYC_P < 1) begin : g_param_check
    $error("apb2axi_tag_scheduler: inconsistent TAG_W_P or TIMEOUT_CYC_P");
  end

  tag_state_e           st_q [TAG_NUM_P];
  tag_state_e           st_d [TAG_NUM_P];
  logic [TAG_NUM_P-1:0] dir_q, dir_d;
  logic [TAG_NUM_P-1:0] err_q, err_d;
  logic                 rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d;
  logic [TAG_W_P-1:0]   rd_tag_q, rd_tag_d, wr_tag_q, wr_tag_d;
  logic [TAG_W_P-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic                 overflow_q, overflow_d, perr_q, perr_d;

  logic [TAG_NUM_P-1:0] free_vec, rd_req, wr_req;
  logic                 free_found;
  logic [TAG_W_P-1:0]   free_idx;
  logic [TAG_W_P-1:0]   rd_grant, wr_grant;
  logic                 rd_any, wr_any;

`ifdef APB2AXI_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC_P + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC_P - 1);

  logic [CNT_W-1:0]   cnt_q [TAG_NUM_P];
  logic [CNT_W-1:0]   cnt_d [TAG_NUM_P];
  logic               to_pulse_q, to_pulse_d;
  logic [TAG_W_P-1:0] to_tag_q, to_tag_d;
`endif

  // Returns {found, index} of the lowest set bit.
  function automatic logic [TAG_W_P:0] lowest_free(input logic [TAG_NUM_P-1:0] fv);
    logic [TAG_W_P:0] r;
    r = '0;
    for (int i = TAG_NUM_P - 1; i >= 0; i--) begin
      if (fv[i]) r = {1'b1, TAG_W_P'(i)};
    end
    return r;
  endfunction

  always_comb begin
    free_vec = '0;
    rd_req   = '0;
    wr_req   = '0;
    for (int i = 0; i < TAG_NUM_P; i++) begin
      free_vec[i] = (st_q[i] == TAG_FREE);
      rd_req[i]   = (st_q[i] == TAG_PEND) && !dir_q[i];
      wr_req[i]   = (st_q[i] == TAG_PEND) &&  dir_q[i];
    end
  end

  assign {free_found, free_idx} = lowest_free(free_vec);
  assign alloc_tag = free_idx;
  assign full      = !free_found;

  apb2axi_rr_arbiter #(.N(TAG_NUM_P), .W(TAG_W_P)) u_rd_arb (
    .req       (rd_req),
    .ptr       (rd_ptr_q),
    .grant_idx (rd_grant),
    .grant_any (rd_any)
  );

  apb2axi_rr_arbiter #(.N(TAG_NUM_P), .W(TAG_W_P)) u_wr_arb (
    .req       (wr_req),
    .ptr       (wr_ptr_q),
    .grant_idx (wr_grant),
    .grant_any (wr_any)
  );

  always_comb begin
    st_d       = st_q;
    dir_d      = dir_q;
    err_d      = err_q;
    rd_valid_d = rd_valid_q;
    rd_tag_d   = rd_tag_q;
    rd_ptr_d   = rd_ptr_q;
    wr_valid_d = wr_valid_q;
    wr_tag_d   = wr_tag_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    perr_d     = perr_q;
`ifdef APB2AXI_SCHED_TIMEOUT_EN
    cnt_d      = cnt_q;
    to_pulse_d = 1'b0;
    to_tag_d   = to_tag_q;
`endif

    if (rel_valid) begin
      if (st_q[rel_tag] == TAG_DONE) st_d[rel_tag] = TAG_FREE;
      else                           perr_d = 1'b1;
    end

    // A completion racing its own issue sees a PEND tag and is rejected here.
    if (cpl_valid) begin
      if (st_q[cpl_tag] == TAG_ISSUED) begin
        st_d[cpl_tag]  = TAG_DONE;
        err_d[cpl_tag] = cpl_err;
      end else begin
        perr_d = 1'b1;
      end
    end

    if (commit_pulse) begin
      if (free_found) begin
        st_d[free_idx]  = TAG_PEND;
        dir_d[free_idx] = commit_is_write;
        err_d[free_idx] = 1'b0;
      end else begin
        overflow_d = 1'b1;
      end
    end

`ifdef APB2AXI_SCHED_TIMEOUT_EN
    for (int i = 0; i < TAG_NUM_P; i++) begin
      if (st_q[i] == TAG_ISSUED && st_d[i] == TAG_ISSUED) begin
        if (cnt_q[i] == CNT_LIM) begin
          st_d[i]  = TAG_DONE;
          err_d[i] = 1'b1;
          if (!to_pulse_d) to_tag_d = TAG_W_P'(i);
          to_pulse_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
`endif

    if (rd_valid_q) begin
      if (rd_issue_ready) begin
        st_d[rd_tag_q] = TAG_ISSUED;
        rd_valid_d     = 1'b0;
        rd_ptr_d       = rd_tag_q;
`ifdef APB2AXI_SCHED_TIMEOUT_EN
        cnt_d[rd_tag_q] = '0;
`endif
      end
    end else if (rd_any) begin
      rd_valid_d = 1'b1;
      rd_tag_d   = rd_grant;
    end

    if (wr_valid_q) begin
      if (wr_issue_ready) begin
        st_d[wr_tag_q] = TAG_ISSUED;
        wr_valid_d     = 1'b0;
        wr_ptr_d       = wr_tag_q;
`ifdef APB2AXI_SCHED_TIMEOUT_EN
        cnt_d[wr_tag_q] = '0;
`endif
      end
    end else if (wr_any) begin
      wr_valid_d = 1'b1;
      wr_tag_d   = wr_grant;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < TAG_NUM_P; i++) st_q[i] <= TAG_FREE;
      dir_q      <= '0;
      err_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_tag_q   <= '0;
      rd_ptr_q   <= '0;
      wr_valid_q <= 1'b0;
      wr_tag_q   <= '0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_tag_q   <= rd_tag_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_valid_q <= wr_valid_d;
      wr_tag_q   <= wr_tag_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
      perr_q     <= perr_d;
    end
  end

`ifdef APB2AXI_SCHED_TIMEOUT_EN
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < TAG_NUM_P; i++) cnt_q[i] <= '0;
      to_pulse_q <= 1'b0;
      to_tag_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      to_pulse_q <= to_pulse_d;
      to_tag_q   <= to_tag_d;
    end
  end

  assign timeout_pulse = to_pulse_q;
  assign timeout_tag   = to_tag_q;
`endif

  for (genvar g = 0; g < TAG_NUM_P; g++) begin : g_state_out
    assign tag_state[TAG_STATE_W*g +: TAG_STATE_W] = st_q[g];
  end

  assign tag_err        = err_q;
  assign rd_issue_valid = rd_valid_q;
  assign rd_issue_tag   = rd_tag_q;
  assign wr_issue_valid = wr_valid_q;
  assign wr_issue_tag   = wr_tag_q;
  assign overflow       = overflow_q;
  assign proto_err      = perr_q;

endmodule

`default_nettype wire

// File: tb/tb_apb2axi_tag_scheduler.sv
// ============================================================================
// Module  : tb_apb2axi_tag_scheduler
// Purpose : Directed self-checking bench for apb2axi_tag_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb2axi_tag_scheduler;
  import apb2axi_pkg::*;

  localparam int N = TAG_NUM;
  localparam int W = TAG_W;

  logic           pclk = 1'b0;
  logic           preset = 1'b1;
  logic           commit_pulse = 1'b0, commit_is_write = 1'b0;
  logic [W-1:0]   alloc_tag;
  logic           full;
  logic           rd_issue_valid, wr_issue_valid;
  logic [W-1:0]   rd_issue_tag, wr_issue_tag;
  logic           rd_issue_ready = 1'b0, wr_issue_ready = 1'b0;
  logic           cpl_valid = 1'b0, cpl_err = 1'b0;
  logic [W-1:0]   cpl_tag = '0;
  logic           rel_valid = 1'b0;
  logic [W-1:0]   rel_tag = '0;
  logic [2*N-1:0] tag_state;
  logic [N-1:0]   tag_err;
  logic           overflow, proto_err;
`ifdef APB2AXI_SCHED_TIMEOUT_EN
  logic           timeout_pulse;
  logic [W-1:0]   timeout_tag;
`endif

  int tests = 0;
  int fails = 0;

  always #5 pclk = ~pclk;

  apb2axi_tag_scheduler #(
    .TAG_NUM_P     (N),
    .TAG_W_P       (W),
`ifdef APB2AXI_SCHED_TIMEOUT_EN
    .TIMEOUT_CYC_P (16)
`else
    .TIMEOUT_CYC_P (1024)
`endif
  ) dut (
    .pclk            (pclk),
    .preset          (preset),
    .commit_pulse    (commit_pulse),
    .commit_is_write (commit_is_write),
    .alloc_tag       (alloc_tag),
    .full            (full),
    .rd_issue_valid  (rd_issue_valid),
    .rd_issue_tag    (rd_issue_tag),
    .rd_issue_ready  (rd_issue_ready),
    .wr_issue_valid  (wr_issue_valid),
    .wr_issue_tag    (wr_issue_tag),
    .wr_issue_ready  (wr_issue_ready),
    .cpl_valid       (cpl_valid),
    .cpl_tag         (cpl_tag),
    .cpl_err         (cpl_err),
    .rel_valid       (rel_valid),
    .rel_tag         (rel_tag),
    .tag_state       (tag_state),
    .tag_err         (tag_err),
    .overflow        (overflow),
    .proto_err       (proto_err)
`ifdef APB2AXI_SCHED_TIMEOUT_EN
    ,
    .timeout_pulse   (timeout_pulse),
    .timeout_tag     (timeout_tag)
`endif
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    tests++; if (tag_state !== '0) begin fails++; $display("FAIL reset_state: got %h want 0", tag_state); end
    tests++; if (tag_err !== '0) begin fails++; $display("FAIL reset_err: got %h want 0", tag_err); end
    tests++; if (full !== 1'b0 || alloc_tag !== '0) begin fails++; $display("FAIL reset_alloc: full=%b alloc=%0d want 0/0", full, alloc_tag); end
    tests++; if ({rd_issue_valid, wr_issue_valid} !== 2'b00 || rd_issue_tag !== '0 || wr_issue_tag !== '0) begin
      fails++; $display("FAIL reset_issue: valids=%b%b tags=%0d/%0d want 0", rd_issue_valid, wr_issue_valid, rd_issue_tag, wr_issue_tag); end
    tests++; if (overflow !== 1'b0 || proto_err !== 1'b0) begin fails++; $display("FAIL reset_sticky: ovf=%b perr=%b want 0/0", overflow, proto_err); end
    preset = 1'b0;
    tick();
  endtask

  task automatic test_commit_issue();
    tests++; if (alloc_tag !== 3'd0) begin fails++; $display("FAIL commit_alloc0: got %0d want 0", alloc_tag); end
    commit_pulse = 1'b1; commit_is_write = 1'b0;
    tick();
    tests++; if (alloc_tag !== 3'd1) begin fails++; $display("FAIL commit_alloc1: got %0d want 1", alloc_tag); end
    commit_is_write = 1'b1;
    tick();
    tests++; if (alloc_tag !== 3'd2) begin fails++; $display("FAIL commit_alloc2: got %0d want 2", alloc_tag); end
    tests++; if (rd_issue_valid !== 1'b1 || rd_issue_tag !== 3'd0 || wr_issue_valid !== 1'b0) begin
      fails++; $display("FAIL first_rd_offer: rv=%b rt=%0d wv=%b want 1/0/0", rd_issue_valid, rd_issue_tag, wr_issue_valid); end
    commit_is_write = 1'b0;
    tick();
    commit_pulse = 1'b0;
    tests++; if (tag_state !== 16'h0015) begin fails++; $display("FAIL commit_state: got %h want 0015", tag_state); end
    tests++; if (rd_issue_valid !== 1'b1 || rd_issue_tag !== 3'd0 || wr_issue_valid !== 1'b1 || wr_issue_tag !== 3'd1) begin
      fails++; $display("FAIL both_offers: rv=%b rt=%0d wv=%b wt=%0d want 1/0/1/1", rd_issue_valid, rd_issue_tag, wr_issue_valid, wr_issue_tag); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++; if (rd_issue_valid !== 1'b1 || rd_issue_tag !== 3'd0) begin
        fails++; $display("FAIL hold_stable[%0d]: rv=%b rt=%0d want 1/0", i, rd_issue_valid, rd_issue_tag); end
    end
    tests++; if (tag_state[1:0] !== 2'd1) begin fails++; $display("FAIL hold_pend: got %0d want 1", tag_state[1:0]); end
    rd_issue_ready = 1'b1;
    tick();
    rd_issue_ready = 1'b0;
    tests++; if (tag_state[1:0] !== 2'd2 || rd_issue_valid !== 1'b0) begin
      fails++; $display("FAIL handshake: st0=%0d rv=%b want 2/0", tag_state[1:0], rd_issue_valid); end
    tick();
    tests++; if (rd_issue_valid !== 1'b1 || rd_issue_tag !== 3'd2) begin
      fails++; $display("FAIL next_rd_offer: rv=%b rt=%0d want 1/2", rd_issue_valid, rd_issue_tag); end
  endtask

  task automatic test_full();
    for (int k = 0; k < 5; k++) begin
      tests++; if (alloc_tag !== 3'(3 + k)) begin fails++; $display("FAIL fill_alloc[%0d]: got %0d want %0d", k, alloc_tag, 3 + k); end
      commit_pulse = 1'b1; commit_is_write = (k % 2 == 0);
      tick();
    end
    commit_pulse = 1'b0;
    tests++; if (full !== 1'b1 || alloc_tag !== 3'd0 || overflow !== 1'b0) begin
      fails++; $display("FAIL full_flag: full=%b alloc=%0d ovf=%b want 1/0/0", full, alloc_tag, overflow); end
    tests++; if (tag_state !== 16'h5556) begin fails++; $display("FAIL full_state: got %h want 5556", tag_state); end
    commit_pulse = 1'b1;
    tick();
    commit_pulse = 1'b0;
    tests++; if (overflow !== 1'b1 || full !== 1'b1 || tag_state !== 16'h5556) begin
      fails++; $display("FAIL overflow: ovf=%b full=%b st=%h want 1/1/5556", overflow, full, tag_state); end
    rd_issue_ready = 1'b1; wr_issue_ready = 1'b1;
    repeat (40) tick();
    rd_issue_ready = 1'b0; wr_issue_ready = 1'b0;
    tests++; if (tag_state !== 16'hAAAA || rd_issue_valid !== 1'b0 || wr_issue_valid !== 1'b0) begin
      fails++; $display("FAIL all_issued: st=%h rv=%b wv=%b want aaaa/0/0", tag_state, rd_issue_valid, wr_issue_valid); end
    cpl_valid = 1'b1; cpl_tag = 3'd5; cpl_err = 1'b0;
    tick();
    cpl_valid = 1'b0;
    tests++; if (tag_state[11:10] !== 2'd3) begin fails++; $display("FAIL cpl5_done: got %0d want 3", tag_state[11:10]); end
    rel_valid = 1'b1; rel_tag = 3'd5;
    tick();
    rel_valid = 1'b0;
    tests++; if (full !== 1'b0 || alloc_tag !== 3'd5 || tag_state[11:10] !== 2'd0 || proto_err !== 1'b0) begin
      fails++; $display("FAIL rel5_alloc: full=%b alloc=%0d st5=%0d perr=%b want 0/5/0/0", full, alloc_tag, tag_state[11:10], proto_err); end
  endtask

  task automatic test_cpl_err();
    cpl_valid = 1'b1; cpl_tag = 3'd3; cpl_err = 1'b1;
    tick();
    cpl_valid = 1'b0; cpl_err = 1'b0;
    tests++; if (tag_state[7:6] !== 2'd3 || tag_err !== 8'h08) begin
      fails++; $display("FAIL cpl3_err: st3=%0d err=%h want 3/08", tag_state[7:6], tag_err); end
    rel_valid = 1'b1; rel_tag = 3'd3;
    tick();
    tests++; if (tag_state[7:6] !== 2'd0 || proto_err !== 1'b0 || alloc_tag !== 3'd3) begin
      fails++; $display("FAIL rel3: st3=%0d perr=%b alloc=%0d want 0/0/3", tag_state[7:6], proto_err, alloc_tag); end
    tick();
    rel_valid = 1'b0;
    tests++; if (proto_err !== 1'b1 || tag_state[7:6] !== 2'd0) begin
      fails++; $display("FAIL double_rel: perr=%b st3=%0d want 1/0", proto_err, tag_state[7:6]); end
  endtask

  task automatic test_same_cycle();
    cpl_valid = 1'b1; cpl_tag = 3'd6;
    tick();
    commit_pulse = 1'b1; commit_is_write = 1'b0;
    cpl_tag = 3'd4;
    rel_valid = 1'b1; rel_tag = 3'd6;
    #1;
    tests++; if (alloc_tag === 3'd6 || alloc_tag !== 3'd3) begin fails++; $display("FAIL same_alloc: got %0d want 3", alloc_tag); end
    tick();
    commit_pulse = 1'b0; cpl_valid = 1'b0; rel_valid = 1'b0;
    tests++; if (tag_state !== 16'h836A) begin fails++; $display("FAIL same_state: got %h want 836a", tag_state); end
    tests++; if (tag_err !== 8'h00 || alloc_tag !== 3'd5 || proto_err !== 1'b1) begin
      fails++; $display("FAIL same_misc: err=%h alloc=%0d perr=%b want 00/5/1", tag_err, alloc_tag, proto_err); end
    tick();
    tests++; if (rd_issue_valid !== 1'b1 || rd_issue_tag !== 3'd3) begin
      fails++; $display("FAIL same_offer: rv=%b rt=%0d want 1/3", rd_issue_valid, rd_issue_tag); end
  endtask

  task automatic test_reset_mid();
    #2;
    preset = 1'b1;
    #1;
    tests++; if (rd_issue_valid !== 1'b0 || tag_state !== '0 || overflow !== 1'b0 || proto_err !== 1'b0) begin
      fails++; $display("FAIL async_reset: rv=%b st=%h ovf=%b perr=%b want 0", rd_issue_valid, tag_state, overflow, proto_err); end
    tick();
    preset = 1'b0;
    tick();
  endtask

`ifdef APB2AXI_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    logic early;
    early = 1'b0;
    commit_pulse = 1'b1; commit_is_write = 1'b0;
    tick();
    commit_pulse = 1'b0;
    tick();
    tests++; if (rd_issue_valid !== 1'b1 || rd_issue_tag !== 3'd0) begin
      fails++; $display("FAIL to_offer: rv=%b rt=%0d want 1/0", rd_issue_valid, rd_issue_tag); end
    rd_issue_ready = 1'b1;
    tick();
    rd_issue_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (timeout_pulse !== 1'b0) early = 1'b1;
    end
    tests++; if (early !== 1'b0 || tag_state[1:0] !== 2'd2) begin
      fails++; $display("FAIL to_early: early=%b st0=%0d want 0/2", early, tag_state[1:0]); end
    tick();
    tests++; if (timeout_pulse !== 1'b1 || timeout_tag !== 3'd0 || tag_state[1:0] !== 2'd3 || tag_err[0] !== 1'b1) begin
      fails++; $display("FAIL to_fire: p=%b t=%0d st0=%0d e0=%b want 1/0/3/1", timeout_pulse, timeout_tag, tag_state[1:0], tag_err[0]); end
    cpl_valid = 1'b1; cpl_tag = 3'd0;
    tick();
    cpl_valid = 1'b0;
    tests++; if (timeout_pulse !== 1'b0 || proto_err !== 1'b1) begin
      fails++; $display("FAIL to_late_cpl: p=%b perr=%b want 0/1", timeout_pulse, proto_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_commit_issue();
    test_hold();
    test_full();
    test_cpl_err();
    test_same_cycle();
    test_reset_mid();
`ifdef APB2AXI_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb2axi_tag_scheduler.md
Name: apb2axi_tag_scheduler

Overview:
- Owns the life cycle of every gateway directory tag: FREE -> PEND -> ISSUED -> DONE -> FREE.
- Supplies the next free tag to the directory write side on each APB commit.
- Arbitrates pending entries onto separate AXI read and write issue ports using round-robin and a valid/ready handshake.
- Retires tags on AXI completion and on software release.
- Sits between the APB register file/directory and the AXI master engines.

Parameters:
- TAG_NUM_P, default TAG_NUM (package): number of directory entries.
- TAG_W_P, default TAG_W (package): tag index width, equal to clog2(TAG_NUM_P).
- TIMEOUT_CYC_P, default 1024: watchdog limit in cycles. Used only with the optional feature.

Ports:
- pclk  in  1  clock.
- preset  in  1  asynchronous, active-high reset.
- commit_pulse  in  1  APB commit strobe, same strobe the directory sees.
- commit_is_write  in  1  direction of the committed entry.
- alloc_tag  out  TAG_W_P  tag the directory must write on the next commit.
- full  out  1  no FREE tag exists.
- rd_issue_valid  out  1  read entry offered.
- rd_issue_tag  out  TAG_W_P  tag of the offered read entry.
- rd_issue_ready  in  1  read engine accepts.
- wr_issue_valid  out  1  write entry offered.
- wr_issue_tag  out  TAG_W_P  tag of the offered write entry.
- wr_issue_ready  in  1  write engine accepts.
- cpl_valid  in  1  AXI response finished.
- cpl_tag  in  TAG_W_P  tag of the finished response.
- cpl_err  in  1  SLVERR/DECERR seen on that response.
- rel_valid  in  1  software consumed the result.
- rel_tag  in  TAG_W_P  tag being released.
- tag_state  out  2*TAG_NUM_P  packed per-tag state, tag i at bits [2i+1:2i].
- tag_err  out  TAG_NUM_P  per-tag error bit.
- overflow  out  1  sticky: commit arrived while full.
- proto_err  out  1  sticky: illegal completion or release.

Behaviour:
- Reset values: all tags FREE; tag_err=0; all valids=0; issue tags=0; overflow=0; proto_err=0; round-robin pointers=0.
- State encoding: FREE=0, PEND=1, ISSUED=2, DONE=3.
- alloc_tag: combinational, lowest-index FREE tag from current registered state.
  - full = no FREE tag; alloc_tag=0 when full.
- Commit:
  - commit_pulse while not full: the tag at alloc_tag goes to PEND at the next edge.
  - The tag's direction bit is stored from commit_is_write.
  - The tag's err bit is cleared.
- Commit while full: dropped, no state change, overflow set (sticky until reset).
- Issue ports: read and write are independent and both may fire in one cycle.
  - Each port holds its own round-robin pointer over PEND tags of its direction.
  - Search starts at pointer+1 and wraps modulo TAG_NUM_P.
  - When valid is low and a candidate exists, the port registers valid=1 and the candidate tag.
  - Earliest issue_valid: 2 cycles after commit_pulse.
  - While valid=1 and ready=0: tag and valid are held stable.
  - On the valid&&ready edge:
    - The tag goes PEND -> ISSUED.
    - valid drops for one cycle; back-to-back issues are therefore spaced 2 cycles apart.
    - The pointer updates to the issued tag.
- Completion: cpl_valid on an ISSUED tag gives ISSUED -> DONE, with tag_err set to cpl_err.
  - cpl_valid on a non-ISSUED tag: ignored, proto_err set.
- Release: rel_valid on a DONE tag gives DONE -> FREE.
  - rel_valid on any other state: ignored, proto_err set.
- Same-cycle events:
  - Commit, completion, release and both issues may all occur in one cycle on distinct tags; all take effect.
  - Release of tag T together with a commit: alloc_tag uses pre-edge state, so T is reallocated no earlier than the next cycle.
  - Completion of a tag in the same cycle as its issue handshake is impossible by construction; if it occurs, proto_err is set and the issue wins.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously), and offered valids drop at once.

Optional Feature:
- Macro: APB2AXI_SCHED_TIMEOUT_EN.
- Defined:
  - Each ISSUED tag runs a saturating cycle counter, cleared on entry to ISSUED.
  - On reaching TIMEOUT_CYC_P the tag is forced to DONE with tag_err=1.
  - Extra output timeout_pulse (1 cycle) and timeout_tag (TAG_W_P).
  - A completion that arrives later for that tag sets proto_err.
- Undefined: no counters, no extra ports; an ISSUED tag stays ISSUED until completed.

Decomposition:
- Package apb2axi_pkg gets:
  - tag_state_e enum (FREE/PEND/ISSUED/DONE).
  - TAG_STATE_W=2.
  - the timeout default constant.
- Sub-module apb2axi_rr_arbiter(N, request vector, pointer -> grant index and any-grant).
  - Instantiated twice: read and write.
- Lowest-free search is a small function local to the block.

Test Plan:
- Reset, then 3 commits with dir R,W,R -> alloc_tag 0,1,2; tag_state shows PEND on tags 0-2; rd_issue_tag=0 first, wr_issue_tag=1 in the same cycle.
- Hold rd_issue_ready=0 for 10 cycles -> rd_issue_valid and rd_issue_tag=0 stable; tag 0 stays PEND; then ready=1 -> tag 0 ISSUED, next read offer is tag 2.
- Fill all TAG_NUM_P tags, then one more commit -> full=1, overflow=1, no state change; release one DONE tag 5 -> next alloc_tag=5.
- cpl_valid tag 3 with cpl_err=1 -> tag 3 DONE, tag_err[3]=1; rel_valid tag 3 -> FREE; a second rel_valid on tag 3 -> proto_err=1.
- Same-cycle commit, completion of tag 4 and release of tag 6 -> all three state updates visible on the next cycle; alloc_tag does not equal 6 during that cycle.
- With APB2AXI_SCHED_TIMEOUT_EN and TIMEOUT_CYC_P=16: issue tag 0 and never complete it -> timeout_pulse with tag 0 exactly 16 cycles after issue, tag 0 DONE, tag_err[0]=1.
